// File: rtl/alu_issue_ctrl.sv
// Issue sequencer in front of a registered ALU: decodes opcode/funct into an ALU
// control code, holds operands for the ALU latency and returns result/zero/illegal.
module alu_issue_ctrl #(
  parameter int ALU_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_opcode,
  input  logic [5:0]  req_funct,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_control,
  input  logic [31:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_illegal
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  localparam logic [3:0] LAST_COUNT = 4'(ALU_LATENCY - 1);

  state_t     state, state_next;
  logic [3:0] count;
  logic       dec_legal;
  logic [2:0] dec_ctrl;
  logic       accept;

  always_comb begin
    dec_legal = 1'b1;
    dec_ctrl  = 3'b000;
    case (req_opcode)
      6'h00: begin
        case (req_funct)
          6'h24:   dec_ctrl = 3'b000;
          6'h25:   dec_ctrl = 3'b001;
          6'h20:   dec_ctrl = 3'b010;
          6'h22:   dec_ctrl = 3'b011;
          6'h18:   dec_ctrl = 3'b111;
          default: dec_legal = 1'b0;
        endcase
      end
      6'h08, 6'h23, 6'h2B: dec_ctrl = 3'b010;
      6'h0C:   dec_ctrl = 3'b000;
      6'h0D:   dec_ctrl = 3'b001;
      6'h04:   dec_ctrl = 3'b011;
      default: dec_legal = 1'b0;
    endcase
  end

  // req_ready is gated by reset so it stays low for the whole reset pulse.
  assign req_ready = (state == IDLE) && !reset;
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = dec_legal ? ISSUE : RESP;
      ISSUE:   if (count == LAST_COUNT) state_next = CAPTURE;
      CAPTURE: state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count       <= 4'd0;
      alu_a       <= 32'd0;
      alu_b       <= 32'd0;
      alu_control <= 3'b000;
      rsp_result  <= 32'd0;
      rsp_zero    <= 1'b0;
      rsp_illegal <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_a <= req_a;
            alu_b <= req_b;
            if (dec_legal) begin
              alu_control <= dec_ctrl;
              count       <= 4'd0;
            end else begin
              // Illegal ops bypass the ALU; the old control code is left alone.
              rsp_result  <= 32'd0;
              rsp_zero    <= 1'b1;
              rsp_illegal <= 1'b1;
            end
          end
        end
        ISSUE: count <= count + 4'd1;
        CAPTURE: begin
          rsp_result  <= alu_result;
          rsp_zero    <= (alu_result == 32'd0);
          rsp_illegal <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: table of single operations on a latency-1
// instance plus stall, mid-operation reset and latency-3 sequences.
module tb_alu_issue_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Instance with ALU_LATENCY = 1
  logic        req_valid = 0, req_ready, rsp_valid, rsp_ready = 0, rsp_zero, rsp_illegal;
  logic [5:0]  req_opcode = 0, req_funct = 0;
  logic [31:0] req_a = 0, req_b = 0, alu_a, alu_b, alu_result, rsp_result;
  logic [2:0]  alu_control;

  // Instance with ALU_LATENCY = 3
  logic        req_valid3 = 0, req_ready3, rsp_valid3, rsp_ready3 = 0, rsp_zero3, rsp_illegal3;
  logic [5:0]  req_opcode3 = 0, req_funct3 = 0;
  logic [31:0] req_a3 = 0, req_b3 = 0, alu_a3, alu_b3, alu_result3, rsp_result3;
  logic [2:0]  alu_control3;

  alu_issue_ctrl #(.ALU_LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_funct(req_funct), .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_illegal(rsp_illegal)
  );

  alu_issue_ctrl #(.ALU_LATENCY(3)) u_dut3 (
    .clk(clk), .reset(reset), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_opcode(req_opcode3), .req_funct(req_funct3), .req_a(req_a3), .req_b(req_b3),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_control(alu_control3), .alu_result(alu_result3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_result(rsp_result3),
    .rsp_zero(rsp_zero3), .rsp_illegal(rsp_illegal3)
  );

  // Registered ALU models
  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] c);
    case (c)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b011:  return a - b;
      3'b111:  return a * b;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) alu_result <= alu_fn(alu_a, alu_b, alu_control);

  logic [31:0] pipe3 [3];
  always @(posedge clk) begin
    pipe3[0] <= alu_fn(alu_a3, alu_b3, alu_control3);
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign alu_result3 = pipe3[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  ctrl;     // alu_control expected after accept
    logic        illegal;
    logic [31:0] result;
    logic        zero;
  } vec_t;

  vec_t vecs [13];

  task automatic do_op(input string nm, input vec_t v);
    int n;
    @(negedge clk);
    chk({nm, ".req_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1; req_opcode = v.opcode; req_funct = v.funct; req_a = v.a; req_b = v.b;
    @(posedge clk);
    #1 req_valid = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk({nm, ".alu_control"}, {29'd0, alu_control}, {29'd0, v.ctrl});
        chk({nm, ".alu_a"}, alu_a, v.a);
        chk({nm, ".req_ready_busy"}, {31'd0, req_ready}, 32'd0);
      end
    end while (!rsp_valid && n < 20);
    chk({nm, ".latency"}, n, v.illegal ? 32'd1 : 32'd3);
    chk({nm, ".rsp_result"}, rsp_result, v.result);
    chk({nm, ".rsp_zero"}, {31'd0, rsp_zero}, {31'd0, v.zero});
    chk({nm, ".rsp_illegal"}, {31'd0, rsp_illegal}, {31'd0, v.illegal});
    rsp_ready = 1;
    @(posedge clk);
    #1 rsp_ready = 0;
    @(negedge clk);
    chk({nm, ".idle_ready"}, {31'd0, req_ready}, 32'd1);
    chk({nm, ".idle_valid"}, {31'd0, rsp_valid}, 32'd0);
    $display("op %s opcode=%02h funct=%02h a=%08h b=%08h result=%08h zero=%0d illegal=%0d",
             nm, v.opcode, v.funct, v.a, v.b, rsp_result, rsp_zero, rsp_illegal);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, ".rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({nm, ".req_ready"}, {31'd0, req_ready}, 32'd0);
    chk({nm, ".alu_a"}, alu_a, 32'd0);
    chk({nm, ".alu_b"}, alu_b, 32'd0);
    chk({nm, ".alu_control"}, {29'd0, alu_control}, 32'd0);
    chk({nm, ".rsp_result"}, rsp_result, 32'd0);
    chk({nm, ".rsp_flags"}, {30'd0, rsp_zero, rsp_illegal}, 32'd0);
  endtask

  vec_t add_v;

  initial begin
    vecs[0]  = '{6'h00, 6'h20, 32'd5,          32'd7,          3'b010, 1'b0, 32'd12,         1'b0};
    vecs[1]  = '{6'h04, 6'h00, 32'h1234,       32'h1234,       3'b011, 1'b0, 32'd0,          1'b1};
    vecs[2]  = '{6'h00, 6'h20, 32'hFFFFFFFF,   32'd1,          3'b010, 1'b0, 32'd0,          1'b1};
    vecs[3]  = '{6'h00, 6'h18, 32'h10000,      32'h10000,      3'b111, 1'b0, 32'd0,          1'b1};
    vecs[4]  = '{6'h00, 6'h18, 32'd6,          32'd7,          3'b111, 1'b0, 32'd42,         1'b0};
    vecs[5]  = '{6'h3F, 6'h00, 32'd9,          32'd9,          3'b111, 1'b1, 32'd0,          1'b1};
    vecs[6]  = '{6'h00, 6'h24, 32'hFF00FF00,   32'h0FF00FF0,   3'b000, 1'b0, 32'h0F000F00,   1'b0};
    vecs[7]  = '{6'h08, 6'h00, 32'd10,         32'd20,         3'b010, 1'b0, 32'd30,         1'b0};
    vecs[8]  = '{6'h00, 6'h22, 32'd3,          32'd5,          3'b011, 1'b0, 32'hFFFFFFFE,   1'b0};
    vecs[9]  = '{6'h23, 6'h00, 32'd100,        32'd4,          3'b010, 1'b0, 32'd104,        1'b0};
    vecs[10] = '{6'h0C, 6'h00, 32'hF0,         32'h0F,         3'b000, 1'b0, 32'd0,          1'b1};
    vecs[11] = '{6'h00, 6'h3F, 32'd1,          32'd2,          3'b000, 1'b1, 32'd0,          1'b1};
    vecs[12] = '{6'h2B, 6'h00, 32'h7FFFFFFF,   32'd1,          3'b010, 1'b0, 32'h80000000,   1'b0};
    add_v    = vecs[0];

    // Reset state
    #1;
    chk_reset_outputs("por");
    repeat (2) @(negedge clk);
    reset = 0;
    #1 chk("por.release_ready", {31'd0, req_ready}, 32'd1);

    foreach (vecs[i]) do_op($sformatf("vec%0d", i), vecs[i]);

    // Stalled response: ORI result held while rsp_ready stays low
    begin
      int n;
      @(negedge clk);
      req_valid = 1; req_opcode = 6'h0D; req_funct = 0; req_a = 32'hF0; req_b = 32'h0F;
      @(posedge clk);
      #1 req_valid = 0;
      n = 0;
      do begin @(negedge clk); n++; end while (!rsp_valid && n < 20);
      chk("stall.latency", n, 32'd3);
      for (int c = 0; c < 10; c++) begin
        if (c == 5) begin
          req_valid = 1; req_opcode = 6'h00; req_funct = 6'h20; req_a = 1; req_b = 1;
        end
        @(negedge clk);
        req_valid = 0;
        chk("stall.rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("stall.rsp_result", rsp_result, 32'hFF);
        chk("stall.req_ready", {31'd0, req_ready}, 32'd0);
      end
      rsp_ready = 1;
      @(posedge clk);
      #1 rsp_ready = 0;
      @(negedge clk);
      chk("stall.idle_ready", {31'd0, req_ready}, 32'd1);
      repeat (4) @(negedge clk);
      chk("stall.no_ghost", {31'd0, rsp_valid}, 32'd0);
      $display("op stall ori result=%08h", rsp_result);
    end

    // Reset while in ISSUE
    @(negedge clk);
    req_valid = 1; req_opcode = 6'h00; req_funct = 6'h20; req_a = 3; req_b = 4;
    @(posedge clk);
    #1 req_valid = 0;
    @(negedge clk);
    reset = 1;
    #1 chk_reset_outputs("rst_issue");
    @(negedge clk);
    reset = 0;
    #1 chk("rst_issue.release_ready", {31'd0, req_ready}, 32'd1);
    repeat (3) @(negedge clk);
    chk("rst_issue.discarded", {31'd0, rsp_valid}, 32'd0);
    $display("op reset_in_issue done");
    do_op("post_rst_issue", add_v);

    // Reset while in RESP
    begin
      int n;
      @(negedge clk);
      req_valid = 1; req_opcode = 6'h00; req_funct = 6'h25; req_a = 32'h1; req_b = 32'h2;
      @(posedge clk);
      #1 req_valid = 0;
      n = 0;
      do begin @(negedge clk); n++; end while (!rsp_valid && n < 20);
      chk("rst_resp.rsp_result", rsp_result, 32'd3);
      reset = 1;
      #1 chk_reset_outputs("rst_resp");
      @(negedge clk);
      reset = 0;
      #1 chk("rst_resp.release_ready", {31'd0, req_ready}, 32'd1);
      $display("op reset_in_resp done");
    end
    do_op("post_rst_resp", add_v);

    // Latency-3 instance
    begin
      int n;
      @(negedge clk);
      req_valid3 = 1; req_opcode3 = 6'h00; req_funct3 = 6'h20; req_a3 = 9; req_b3 = 8;
      @(posedge clk);
      #1 req_valid3 = 0;
      n = 0;
      do begin @(negedge clk); n++; end while (!rsp_valid3 && n < 30);
      chk("lat3.latency", n, 32'd5);
      chk("lat3.rsp_result", rsp_result3, 32'd17);
      chk("lat3.rsp_flags", {30'd0, rsp_zero3, rsp_illegal3}, 32'd0);
      chk("lat3.alu_control", {29'd0, alu_control3}, 32'd2);
      rsp_ready3 = 1;
      @(posedge clk);
      #1 rsp_ready3 = 0;
      @(negedge clk);
      chk("lat3.idle_ready", {31'd0, req_ready3}, 32'd1);
      $display("op lat3 add result=%08h cycles=%0d", rsp_result3, n);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
